// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the data memory arbiter.
// slave = arbiter view, master = requesters plus memory (the surrounding system).
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;

    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    logic              mem_we;
    logic              mem_mode;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_dout,
        output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
        output rdata, err, busy,
        output mem_we, mem_mode, mem_addr, mem_din
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_dout,
        input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
        input  rdata, err, busy,
        input  mem_we, mem_mode, mem_addr, mem_din
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the core (r0) and the
// debug/dump engine (r1); one access in flight, read latency tracked by a down-counter.
//   state   | meaning
//   S_IDLE  | arbitrate; writes complete in the grant cycle, reads move to S_RWAIT
//   S_RWAIT | hold read address, count down RD_LAT cycles, then capture mem_dout
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic {S_IDLE = 1'b0, S_RWAIT = 1'b1} state_t;

    localparam int              CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prio;
    logic              r_owner;
    logic              r_oor;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_err;

    logic              w_sel0;
    logic              w_sel1;
    logic              w_grant;
    logic              w_we;
    logic              w_oor;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // r_prio = 0 favours r0 on a tie, 1 favours r1
    assign w_sel0  = bus.r0_req & (~bus.r1_req | ~r_prio);
    assign w_sel1  = bus.r1_req & (~bus.r0_req |  r_prio);
    // gating with reset keeps gnt and the memory port idle while reset is held
    assign w_grant = reset & (r_state == S_IDLE) & (w_sel0 | w_sel1);
    assign w_we    = w_sel0 ? bus.r0_we    : bus.r1_we;
    assign w_addr  = w_sel0 ? bus.r0_addr  : bus.r1_addr;
    assign w_wdata = w_sel0 ? bus.r0_wdata : bus.r1_wdata;
    assign w_oor   = ({1'b0, w_addr} >= DEPTH_L);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant && !w_we) w_state_nxt = S_RWAIT;
            S_RWAIT: if (r_cnt == '0)      w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.r0_gnt   = w_grant & w_sel0;
        bus.r1_gnt   = w_grant & w_sel1;
        bus.busy     = (r_state == S_RWAIT);
        bus.mem_we   = 1'b0;
        bus.mem_mode = 1'b1;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        if (r_state == S_RWAIT) begin
            bus.mem_addr = r_addr;
        end else if (w_grant) begin
            bus.mem_addr = w_addr;
            if (w_we && !w_oor) begin
                bus.mem_we   = 1'b1;
                bus.mem_mode = 1'b0;
                bus.mem_din  = w_wdata;
            end
        end
    end

    assign bus.rdata     = r_rdata;
    assign bus.r0_rvalid = r_rvalid0;
    assign bus.r1_rvalid = r_rvalid1;
    assign bus.err       = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio    <= 1'b0;
            r_owner   <= 1'b0;
            r_oor     <= 1'b0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err     <= 1'b0;
            if (w_grant) begin
                r_prio <= w_sel0;
                if (w_we) begin
                    r_err <= w_oor;
                end else begin
                    r_owner <= w_sel1;
                    r_oor   <= w_oor;
                    r_addr  <= w_addr;
                    r_cnt   <= CNT_W'(RD_LAT - 1);
                end
            end else if (r_state == S_RWAIT) begin
                if (r_cnt == '0) begin
                    r_rdata   <= r_oor ? '0 : bus.mem_dout;
                    r_rvalid0 <= ~r_owner;
                    r_rvalid1 <= r_owner;
                    r_err     <= r_oor;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end
endmodule
